instr_prefetch: RTL
===================

// Module: instr_prefetch
// PURPOSE
//   Instruction fetch stage directly upstream of the processor core.
//   - Reads 16-bit words from program memory, one per cycle, in sequential order.
//   - Buffers them, each tagged with its PC, in a small FIFO.
//   - Presents them to the core over a valid/ready handshake.
//   - On a branch/jump redirect: flushes the FIFO and any in-flight fetch, then
//     restarts fetching at the new PC.
// PARAMETERS
//   ADDR_W    16  program address width; addresses are word addresses
//   DATA_W    16  instruction word width
//   DEPTH     4   FIFO entries; power of 2, >= 2
//   RESET_PC  0   first fetch address after reset
// PORTS
//   clk          in   1       system clock; all logic on posedge
//   rst          in   1       synchronous, active-high reset
//   imem_req     out  1       read strobe to program memory
//   imem_addr    out  ADDR_W  read address; meaningful only when imem_req=1
//   imem_rdata   in   DATA_W  read data; valid the cycle after imem_req=1
//   instr_valid  out  1       FIFO head holds an instruction
//   instr_ready  in   1       core accepts the head word this cycle
//   instr_out    out  DATA_W  head instruction word
//   instr_pc     out  ADDR_W  address instr_out was fetched from
//   redirect     in   1       flush and refetch from redirect_pc
//   redirect_pc  in   ADDR_W  new fetch address; sampled when redirect=1
// BEHAVIOUR
//   Reset
//   - State: fetch_pc=RESET_PC, count=0, inflight=0.
//   - Outputs: imem_req=0, instr_valid=0, instr_out=0, instr_pc=0.
//   - Any imem_rdata returning the cycle after reset is discarded.
//   Issue
//   - imem_req=1 and imem_addr=fetch_pc when !rst && !redirect && count+inflight<DEPTH.
//   - count and inflight are the registered values.
//   - On issue: fetch_pc <= fetch_pc+1 (mod 2^ADDR_W), inflight <= 1; otherwise inflight <= 0.
//   Capture
//   - If inflight=1, push {imem_rdata, pc_q} into the FIFO at the clock edge.
//   - pc_q is the registered address of the issued request.
//   - The credit rule guarantees the FIFO is never full at a push.
//   Pop
//   - Handshake: instr_valid && instr_ready.
//   - Push and pop in the same cycle: count unchanged.
//   - instr_valid = (count != 0).
//   - instr_out and instr_pc come straight from the FIFO head; they are stable
//     while valid && !ready.
//   Latency
//   - Request at cycle N -> word visible with instr_valid=1 at cycle N+2.
//   - Steady-state throughput is 1 instruction/cycle with instr_ready=1.
//   Redirect (priority over everything except rst)
//   - FIFO cleared (count=0).
//   - inflight cleared; the returning word is dropped.
//   - fetch_pc <= redirect_pc; no request in the redirect cycle.
//   - A pop in the same cycle is absorbed by the flush.
//   - Timing: redirect at cycle R -> request at redirect_pc in R+1 -> instr_valid in R+3.
//   Wrap and reset
//   - fetch_pc wraps from 2^ADDR_W-1 to 0 with no special handling.
//   - rst mid-operation behaves exactly as the initial reset.
// TESTING
//   1. Memory word[i] = 16'h0100+i; release rst, instr_ready=1
//      -> imem_addr 0,1,2,... on consecutive cycles; instr_valid rises 2 cycles
//         after the first req; instr_out 0100,0101,... with instr_pc 0,1,...
//   2. Same memory, instr_ready=0
//      -> exactly 4 requests (addr 0..3), then imem_req=0;
//         instr_out holds 16'h0100, instr_pc=0.
//   3. FIFO holding 3 entries plus one fetch in flight; pulse redirect with
//      redirect_pc=16'h0020
//      -> instr_valid=0 next cycle; next req addr 0x0020;
//         first instr_pc=0x0020; no stale word is ever delivered.
//   4. redirect_pc=16'hFFFF
//      -> requests to FFFF then 0000; instr_pc sequence FFFF, 0000.
//   5. rst asserted for 1 cycle with a req in flight and 2 words buffered
//      -> next cycle instr_valid=0, imem_req=0; after release, fetch restarts
//         at RESET_PC.
//   6. Random instr_ready toggling plus occasional redirects, checked against a
//      scoreboard model
//      -> instr_pc strictly consecutive between redirects; no drops, no
//         duplicates.

Source files
------------

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: sequential fetch from program memory into a small
// PC-tagged FIFO, valid/ready delivery to the core, flush-and-refetch on redirect.
module instr_prefetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [ADDR_W-1:0] tag_q  [DEPTH];

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

  logic issue_c;
  logic push_c;
  logic pop_c;

  // Credit rule: buffered plus in-flight words never exceed the FIFO depth.
  always_comb begin
    issue_c = !rst && !redirect &&
              ((count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
    push_c  = inflight_q && !redirect;
    pop_c   = (count_q != '0) && instr_ready && !redirect;
  end

  assign imem_req    = issue_c;
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instr_out   = data_q[rd_ptr_q];
  assign instr_pc    = tag_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect) begin
      // Flush drops buffered words, the returning word and any same-cycle pop.
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      inflight_d = issue_c;
      if (issue_c) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        pc_d       = fetch_pc_q;
      end
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      data_q     <= '{default: '0};
      tag_q      <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push_c) begin
        data_q[wr_ptr_q] <= imem_rdata;
        tag_q[wr_ptr_q]  <= pc_q;
      end
    end
  end

endmodule
